scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshake on every port.
- Two modes: manual (external select, generalising the cascaded 2:1 select chain) and scan (round-robin over the channels that are presenting data).
- Sits between several producer channels and a single consumer. It replaces hand-cascaded 2:1 mux trees wherever the path needs to be registered or needs flow control.

Parameters:
- WIDTH, 1, data bits per channel.
- CHANNELS, 3, number of input channels; legal range 2 to 16.
- SEL_W, $clog2(CHANNELS), width of select and channel-index fields. Derived as a localparam; must not be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel data valid.
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- sel  in  SEL_W  channel index; used in manual mode only.
- mode  in  1  0 = manual, 1 = scan.
- out_data  out  WIDTH  registered output data.
- out_ch  out  SEL_W  index of the channel that out_data came from.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_data=0, out_ch=0, out_valid=0.
  - Round-robin pointer last=CHANNELS-1, so the first scan grant goes to channel 0.
  - in_ready is 0 while rst is high.
- Transfer rules:
  - An input transfer on channel k occurs when in_valid[k] & in_ready[k].
  - An output transfer occurs when out_valid & out_ready.
- Load enable:
  - load = ~out_valid | out_ready. This gives a single-entry pipeline register with full throughput: one word per cycle when the consumer is always ready.
  - in_ready[k] = load & grant[k]. It is combinational from in_valid, sel, mode and state.
  - There is no combinational path from in_data to any output.
- Manual mode (mode=0):
  - grant = one-hot of sel if sel < CHANNELS and in_valid[sel]=1; otherwise grant = 0.
  - sel >= CHANNELS is out of range: no grant, and the output register drains normally.
- Scan mode (mode=1):
  - grant = the first valid channel searching upward from last+1, wrapping modulo CHANNELS.
  - If no channel is valid, grant = 0.
  - last updates to the granted index only when an input transfer occurs.
  - A stalled grant is not re-arbitrated while load=0, because in_ready is low.
- Register update on clk:
  - If load and the grant is nonzero: out_data <= granted channel's data, out_ch <= granted index, out_valid <= 1.
  - Else if load: out_valid <= 0. out_data and out_ch hold their values.
  - Else: hold all outputs.
- Latency: one cycle from input transfer to out_valid.
- Simultaneous output and input transfer in the same cycle: the new word replaces the old one; no bubble.
- A mode change takes effect on the next arbitration. Data already in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded and no in_ready is issued.
- in_valid[k] is allowed to drop without a transfer; no protocol check is required.

Decomposition:
- Shared package scan_mux_pkg holds:
  - mode encodings MODE_MANUAL=1'b0 and MODE_SCAN=1'b1;
  - max-channel constant MAX_CHANNELS=16.
- One sub-module, rr_arbiter (parameters CHANNELS, SEL_W):
  - inputs: request vector, pointer last, enable;
  - outputs: one-hot grant, encoded grant index, any-grant flag.
- The top level contains manual-select decode, mode mux, pointer register and output register.

Test Plan:
1. Reset and idle: WIDTH=8, CHANNELS=3. Assert rst mid-run with out_valid=1 -> out_valid=0, out_data=0 and in_ready=0 immediately (no clock edge needed). After release, with no valid inputs, out_valid stays 0.
2. Manual select:
   - mode=0, sel=2, in_valid=3'b111, ch2 data=8'hA5, out_ready=1 -> in_ready=3'b100, next cycle out_data=A5 and out_ch=2.
   - sel=3 (out of range) -> in_ready=0 and out_valid falls after one cycle.
3. Scan round-robin: mode=1, all three channels valid, out_ready=1 -> out_ch sequence 0,1,2,0,1 on consecutive cycles, one word per cycle.
4. Scan skip: mode=1, in_valid=3'b101 -> out_ch sequence 0,2,0,2. Raising in_valid[1] after a grant to channel 0 -> next grant is 1.
5. Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data, out_ch and last stay stable, and in_ready=0. Raising out_ready -> the output transfers and the next word loads in the same cycle.
6. Width/channel sweep: CHANNELS=2 and 16, WIDTH=1 and 32 -> random valid/ready traffic. Scoreboard checks per-channel ordering, no lost or duplicated words, and in_ready at most one-hot.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan_mux slice: mode encodings and the channel limit.
package scan_mux_pkg;

  localparam logic MODE_MANUAL  = 1'b0;
  localparam logic MODE_SCAN    = 1'b1;
  localparam int   MAX_CHANNELS = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above 'last', wrapping to the
// lowest requester at or below 'last' when nothing above it is asking.
module rr_arbiter #(
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  input  logic                en,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  logic             hi_hit_s;
  logic             lo_hit_s;
  logic             hi_any_s;
  logic             lo_any_s;
  logic [SEL_W-1:0] hi_idx_s;
  logic [SEL_W-1:0] lo_idx_s;

  // Scan downward so the lowest index in each half wins.
  always_comb begin
    hi_hit_s  = 1'b0;
    lo_hit_s  = 1'b0;
    hi_any_s  = 1'b0;
    lo_any_s  = 1'b0;
    hi_idx_s  = '0;
    lo_idx_s  = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      hi_hit_s = en & req[j] & (SEL_W'(j) >  last);
      lo_hit_s = en & req[j] & (SEL_W'(j) <= last);
      hi_idx_s = hi_hit_s ? SEL_W'(j) : hi_idx_s;
      lo_idx_s = lo_hit_s ? SEL_W'(j) : lo_idx_s;
      hi_any_s = hi_any_s | hi_hit_s;
      lo_any_s = lo_any_s | lo_hit_s;
    end
    any_grant = hi_any_s | lo_any_s;
    grant_idx = hi_any_s ? hi_idx_s : lo_idx_s;
    grant     = any_grant ? ({{(CHANNELS-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered multiplexer with valid/ready on every port; manual
// select or round-robin scan over the channels presenting data.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 3,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("scan_mux: CHANNELS out of range");
  end

  logic [CHANNELS-1:0] man_grant_s;
  logic [CHANNELS-1:0] arb_grant_s;
  logic [CHANNELS-1:0] grant_s;
  logic [SEL_W-1:0]    arb_idx_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic                arb_any_s;
  logic                any_grant_s;
  logic                sel_ok_s;
  logic                load_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    pick_data_s;
  logic [SEL_W-1:0]    last_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_ch_r;
  logic                out_valid_r;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .last      (last_r),
    .en        (mode == MODE_SCAN),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any_grant (arb_any_s)
  );

  // sel can exceed CHANNELS-1 when CHANNELS is not a power of two.
  assign sel_ok_s = (SEL_W+1)'(sel) < (SEL_W+1)'(CHANNELS);

  always_comb begin
    man_grant_s = '0;
    if (sel_ok_s && in_valid[sel]) begin
      man_grant_s[sel] = 1'b1;
    end else begin
      man_grant_s = '0;
    end
  end

  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    case (mode)
      MODE_MANUAL: begin
        grant_s     = man_grant_s;
        grant_idx_s = sel;
      end
      MODE_SCAN: begin
        grant_s     = arb_grant_s;
        grant_idx_s = arb_idx_s;
      end
      default: begin
        grant_s     = '0;
        grant_idx_s = '0;
      end
    endcase
  end

  assign any_grant_s = |grant_s;
  assign load_s      = ~out_valid_r | out_ready;

  always_comb begin
    in_ready = '0;
    if (rst) begin
      in_ready = '0;
    end else if (load_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  assign xfer_s = |(in_valid & in_ready);

  // One-hot AND-OR select keeps an out-of-range sel from indexing past in_data.
  always_comb begin
    pick_data_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pick_data_s = pick_data_s | ({WIDTH{grant_s[k]}} & in_data[k*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= SEL_W'(CHANNELS - 1);
    end else if (xfer_s && (mode == MODE_SCAN)) begin
      last_r <= grant_idx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
    end else if (load_s && any_grant_s) begin
      out_data_r  <= pick_data_s;
      out_ch_r    <= grant_idx_s;
      out_valid_r <= 1'b1;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed vectors on an 8-bit/3-channel instance plus
// random scan traffic on 1-bit/2-channel and 32-bit/16-channel instances.
module tb_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Unified per-instance views: 0 = W8/C3, 1 = W1/C2, 2 = W32/C16
  logic [15:0] s_valid [3];
  logic [31:0] s_data  [3][16];
  logic        s_mode  [3];
  logic [31:0] s_sel   [3];
  logic        s_ordy  [3];
  logic [15:0] o_ready [3];
  logic        o_valid [3];
  logic [31:0] o_data  [3];
  logic [31:0] o_ch    [3];

  logic [23:0]  m_in_data;  logic [2:0]  m_in_valid, m_in_ready;
  logic [1:0]   m_sel, m_out_ch; logic [7:0] m_out_data; logic m_out_valid;
  logic [1:0]   a_in_data, a_in_valid, a_in_ready;
  logic         a_sel, a_out_ch, a_out_data, a_out_valid;
  logic [511:0] b_in_data;  logic [15:0] b_in_valid, b_in_ready;
  logic [3:0]   b_sel, b_out_ch; logic [31:0] b_out_data; logic b_out_valid;

  for (genvar k = 0; k < 16; k++) begin : g_map
    if (k < 3) begin : g_m
      assign m_in_data[k*8 +: 8] = s_data[0][k][7:0];
    end
    if (k < 2) begin : g_a
      assign a_in_data[k] = s_data[1][k][0];
    end
    assign b_in_data[k*32 +: 32] = s_data[2][k];
  end

  assign m_in_valid = s_valid[0][2:0];
  assign a_in_valid = s_valid[1][1:0];
  assign b_in_valid = s_valid[2];
  assign m_sel = s_sel[0][1:0];
  assign a_sel = s_sel[1][0];
  assign b_sel = s_sel[2][3:0];
  assign o_ready[0] = {13'd0, m_in_ready};
  assign o_ready[1] = {14'd0, a_in_ready};
  assign o_ready[2] = b_in_ready;
  assign o_valid[0] = m_out_valid;
  assign o_valid[1] = a_out_valid;
  assign o_valid[2] = b_out_valid;
  assign o_data[0] = {24'd0, m_out_data};
  assign o_data[1] = {31'd0, a_out_data};
  assign o_data[2] = b_out_data;
  assign o_ch[0] = {30'd0, m_out_ch};
  assign o_ch[1] = {31'd0, a_out_ch};
  assign o_ch[2] = {28'd0, b_out_ch};

  scan_mux #(.WIDTH(8), .CHANNELS(3)) u_m (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .sel(m_sel), .mode(s_mode[0]), .out_data(m_out_data), .out_ch(m_out_ch),
    .out_valid(m_out_valid), .out_ready(s_ordy[0]));

  scan_mux #(.WIDTH(1), .CHANNELS(2)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .mode(s_mode[1]), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_valid(a_out_valid), .out_ready(s_ordy[1]));

  scan_mux #(.WIDTH(32), .CHANNELS(16)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .mode(s_mode[2]), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(s_ordy[2]));

  int          n_ch   [3] = '{3, 2, 16};
  logic [31:0] w_mask [3] = '{32'h0000_00FF, 32'h0000_0001, 32'hFFFF_FFFF};

  // Model: the word held in the output register and the round-robin pointer.
  logic        ev [3];
  logic [31:0] ed [3];
  int          ec [3];
  int          el [3];
  logic [31:0] out_seq [3][16];
  logic [15:0] xfer [3];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] v, input logic md, input int s,
                              input int last, input int n);
    if (!md) return (s < n && v[s]) ? s : -1;
    for (int k = 1; k <= n; k++) begin
      if (v[(last + k) % n]) return (last + k) % n;
    end
    return -1;
  endfunction

  function automatic int gsel(input int i);
    return pick(s_valid[i], s_mode[i], int'(s_sel[i]), el[i], n_ch[i]);
  endfunction

  function automatic logic [15:0] exp_ready(input int i);
    int g;
    g = gsel(i);
    if (rst || g < 0 || (ev[i] && !s_ordy[i])) return 16'd0;
    return 16'd1 << g;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ev[i] <= 1'b0; ed[i] <= 32'd0; ec[i] <= 0; el[i] <= n_ch[i] - 1;
      end else if (!ev[i] || s_ordy[i]) begin
        if (gsel(i) >= 0) begin
          ev[i] <= 1'b1;
          ed[i] <= s_data[i][gsel(i)] & w_mask[i];
          ec[i] <= gsel(i);
          if (s_mode[i]) el[i] <= gsel(i);
        end else begin
          ev[i] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus per-channel ordering on the sweep instances.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(exp_ready(i)));
      chk($sformatf("onehot%0d", i), 32'($countones(o_ready[i]) <= 1), 32'd1);
      chk($sformatf("valid%0d", i), 32'(o_valid[i]), 32'(ev[i]));
      chk($sformatf("ch%0d", i), o_ch[i], 32'(ec[i]));
      chk($sformatf("data%0d", i), o_data[i], ed[i]);
      if (i > 0 && o_valid[i] && s_ordy[i]) begin
        chk($sformatf("order%0d", i), o_data[i], out_seq[i][o_ch[i][3:0]] & w_mask[i]);
        out_seq[i][o_ch[i][3:0]] = out_seq[i][o_ch[i][3:0]] + 32'd1;
      end
      xfer[i] = s_valid[i] & o_ready[i];
    end
  end

  task automatic sweep_step();
    for (int i = 1; i < 3; i++) begin
      for (int k = 0; k < n_ch[i]; k++) begin
        if (xfer[i][k]) s_data[i][k] = s_data[i][k] + 32'd1;
      end
      s_valid[i] = 16'($urandom) & 16'((32'd1 << n_ch[i]) - 32'd1);
      s_ordy[i]  = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sweep_step();
  endtask

  task automatic sync_seq();
    for (int i = 1; i < 3; i++)
      for (int k = 0; k < 16; k++) out_seq[i][k] = s_data[i][k];
  endtask

  logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
  logic [1:0] sk_exp [6] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer[i] = 16'd0; s_valid[i] = 16'd0; s_sel[i] = 32'd0;
      s_mode[i] = (i != 0); s_ordy[i] = 1'b1;
      for (int k = 0; k < 16; k++) s_data[i][k] = 32'(k * 1000);
    end
    s_valid[0] = 16'h0007;
    sync_seq();
    #12;
    chk("rst_ready", 32'(m_in_ready), 32'd0);
    chk("rst_valid", 32'(m_out_valid), 32'd0);
    chk("rst_data", 32'(m_out_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid[0] = 16'd0;
    repeat (3) tick();
    chk("idle_valid", 32'(m_out_valid), 32'd0);

    // Manual select, then out-of-range select
    s_data[0][0] = 32'h11; s_data[0][1] = 32'h22; s_data[0][2] = 32'hA5;
    s_valid[0] = 16'h0007; s_sel[0] = 32'd2; s_ordy[0] = 1'b1;
    #1 chk("man_ready", 32'(m_in_ready), 32'h4);
    tick();
    chk("man_data", 32'(m_out_data), 32'hA5);
    chk("man_ch", 32'(m_out_ch), 32'd2);
    s_sel[0] = 32'd3;
    #1 chk("oor_ready", 32'(m_in_ready), 32'd0);
    tick();
    chk("oor_valid", 32'(m_out_valid), 32'd0);
    chk("oor_hold", 32'(m_out_data), 32'hA5);

    // Asynchronous reset while a word is held
    s_sel[0] = 32'd0;
    tick();
    chk("pre_rst_valid", 32'(m_out_valid), 32'd1);
    s_ordy[0] = 1'b0;
    #2 rst = 1'b1;
    sync_seq();
    #1;
    chk("async_valid", 32'(m_out_valid), 32'd0);
    chk("async_data", 32'(m_out_data), 32'd0);
    chk("async_ready", 32'(m_in_ready), 32'd0);
    tick();
    rst = 1'b0;

    // Scan round-robin over three valid channels
    s_mode[0] = 1'b1; s_ordy[0] = 1'b1; s_valid[0] = 16'h0007;
    s_data[0][0] = 32'h10; s_data[0][1] = 32'h11; s_data[0][2] = 32'h12;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("rr_ch%0d", n), 32'(m_out_ch), 32'(rr_exp[n]));
      chk($sformatf("rr_data%0d", n), 32'(m_out_data), 32'h10 + 32'(rr_exp[n]));
    end

    // Scan skipping an idle channel, then channel 1 joins
    rst = 1'b1;
    sync_seq();
    #1 rst = 1'b0;
    s_valid[0] = 16'h0005;
    for (int n = 0; n < 6; n++) begin
      if (n == 5) s_valid[0] = 16'h0007;
      tick();
      chk($sformatf("skip_ch%0d", n), 32'(m_out_ch), 32'(sk_exp[n]));
      chk($sformatf("skip_valid%0d", n), 32'(m_out_valid), 32'd1);
    end

    // Backpressure holds everything, release loads the next word in the same edge
    s_ordy[0] = 1'b0;
    #1 chk("bp_ready", 32'(m_in_ready), 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("bp_ch%0d", n), 32'(m_out_ch), 32'd1);
      chk($sformatf("bp_data%0d", n), 32'(m_out_data), 32'h11);
      chk($sformatf("bp_ready%0d", n), 32'(m_in_ready), 32'd0);
    end
    s_ordy[0] = 1'b1;
    #1 chk("bp_rel_ready", 32'(m_in_ready), 32'h4);
    tick();
    chk("bp_rel_ch", 32'(m_out_ch), 32'd2);
    chk("bp_rel_data", 32'(m_out_data), 32'h12);
    chk("bp_rel_valid", 32'(m_out_valid), 32'd1);

    // Random traffic on every instance, both modes on the 3-channel one
    for (int n = 0; n < 600; n++) begin
      tick();
      s_valid[0] = 16'($urandom_range(0, 7));
      s_mode[0]  = 1'($urandom_range(0, 1));
      s_sel[0]   = 32'($urandom_range(0, 3));
      s_ordy[0]  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 3; k++) s_data[0][k] = 32'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
